// File: rtl/key_expand_multi_if.sv
// ---------------------------------------------------------------------------
// key_expand_multi_if
// Groups the request, status and round-key read signals of key_expand_multi.
//
// Signals:
//   start    request a key expansion (sampled only while the expander idles)
//   key_len  00 = AES-128, 01 = AES-192, 10 = AES-256, 11 = reserved
//   key      256-bit cipher key, MSB-aligned (word 0 = key[255:224])
//   busy     expansion in progress
//   done     one-cycle pulse when the expansion has finished
//   err      one-cycle pulse when a start request was rejected
//   rk_idx   round-key index to read
//   rk_out   selected round key, zero when not valid
//   rk_vld   rk_out holds a fully generated round key
//
// Modports: master drives requests and the read index, slave is the expander.
// ---------------------------------------------------------------------------
interface key_expand_multi_if;
  logic         start;
  logic [1:0]   key_len;
  logic [255:0] key;
  logic         busy;
  logic         done;
  logic         err;
  logic [3:0]   rk_idx;
  logic [127:0] rk_out;
  logic         rk_vld;

  modport master (
    output start, key_len, key, rk_idx,
    input  busy, done, err, rk_out, rk_vld
  );

  modport slave (
    input  start, key_len, key, rk_idx,
    output busy, done, err, rk_out, rk_vld
  );
endinterface

// File: rtl/key_expand_multi.sv
// ---------------------------------------------------------------------------
// key_expand_multi
// Iterative AES key expansion for AES-128/192/256. After an accepted start the
// key is loaded into the word array in one cycle, then one expanded word is
// produced per cycle. Round keys can be read back through a random-access port
// while the expansion is still running; a round key is flagged valid as soon
// as its last word has been written by the current expansion.
//
// Parameters:
//   MAX_NK  largest supported key length in 32-bit words (4, 6 or 8)
//   RD_REG  1 = registered read port (one cycle latency), 0 = combinational
//
// Ports:
//   clk  clock, all state changes on the rising edge
//   rst  asynchronous active-high reset
//   bus  key_expand_multi_if slave modport (request, status and read port)
// ---------------------------------------------------------------------------
module key_expand_multi #(
  parameter int MAX_NK = 8,
  parameter bit RD_REG = 1'b1
) (
  input logic               clk,
  input logic               rst,
  key_expand_multi_if.slave bus
);

  localparam int NW_MAX = 4 * (MAX_NK + 7);
  localparam int NR_MAX = MAX_NK + 6;
  localparam int NF     = NR_MAX + 1;
  localparam int IW     = $clog2(NW_MAX);

  // AES S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, LOAD, GEN, DONE} state_t;

  // Byte b lives at bits [2047-8b -: 8], which is {~b, 3'b111}.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b111} -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [3:0] nk_of(input logic [1:0] m);
    case (m)
      2'b01:   return 4'd6;
      2'b10:   return 4'd8;
      default: return 4'd4;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] m);
    case (m)
      2'b01:   return 4'd12;
      2'b10:   return 4'd14;
      default: return 4'd10;
    endcase
  endfunction

  function automatic logic [IW-1:0] nw_of(input logic [1:0] m);
    case (m)
      2'b01:   return IW'(52);
      2'b10:   return IW'(60);
      default: return IW'(44);
    endcase
  endfunction

  // Modes longer than MAX_NK are rejected, which also lets synthesis prune
  // the datapath for them.
  function automatic logic mode_ok(input logic [1:0] m);
    return (m != 2'b11) && (int'(nk_of(m)) <= MAX_NK);
  endfunction

  state_t          state_q, state_d;
  logic [IW-1:0]   i_q, i_d;
  logic [2:0]      sub_q, sub_d;
  logic [7:0]      rcon_q, rcon_d;
  logic [1:0]      mode_q, mode_d;
  logic [NF-1:0]   flag_q, flag_d;
  logic            err_q, err_d;
  logic [255:0]    key_q, key_d;
  logic [31:0]     w_q [NW_MAX];
  logic [31:0]     w_d [NW_MAX];

  logic [3:0]      nk;
  logic [31:0]     prev_w;
  logic [31:0]     far_w;
  logic [31:0]     t_w;
  logic [31:0]     new_w;
  logic            accept;

  // Word rule: w[i] = w[i-Nk] ^ t, where t depends on the position of i
  // within the current key-length group, tracked by sub_q (no divider).
  always_comb begin
    nk     = nk_of(mode_q);
    prev_w = w_q[i_q - IW'(1)];
    far_w  = w_q[i_q - IW'(nk)];
    if (sub_q == 3'd0) begin
      t_w = sub_word({prev_w[23:0], prev_w[31:24]}) ^ {rcon_q, 24'h000000};
    end else if ((MAX_NK == 8) && (mode_q == 2'b10) && (sub_q == 3'd4)) begin
      t_w = sub_word(prev_w);
    end else begin
      t_w = prev_w;
    end
    new_w  = far_w ^ t_w;
    accept = (state_q == IDLE) && bus.start && mode_ok(bus.key_len);
  end

  // Next-state and datapath updates. Valid flags are cleared the moment a
  // start is accepted so that no round key from an earlier expansion can be
  // reported valid during the new one.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    sub_d   = sub_q;
    rcon_d  = rcon_q;
    mode_d  = mode_q;
    flag_d  = flag_q;
    err_d   = 1'b0;
    key_d   = key_q;
    w_d     = w_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (accept) begin
            key_d   = bus.key;
            mode_d  = bus.key_len;
            flag_d  = '0;
            state_d = LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      LOAD: begin
        for (int k = 0; k < MAX_NK; k++) begin
          if (k < int'(nk)) begin
            w_d[k] = key_q[255 - 32*k -: 32];
          end
        end
        i_d       = IW'(nk);
        sub_d     = 3'd0;
        rcon_d    = 8'h01;
        flag_d    = '0;
        flag_d[0] = 1'b1;
        if (mode_q == 2'b10) begin
          flag_d[1] = 1'b1;
        end
        state_d   = GEN;
      end

      GEN: begin
        w_d[i_q] = new_w;
        if ({1'b0, sub_q} == nk - 4'd1) begin
          sub_d = 3'd0;
        end else begin
          sub_d = sub_q + 3'd1;
        end
        if (sub_q == 3'd0) begin
          rcon_d = xtime(rcon_q);
        end
        if (i_q[1:0] == 2'b11) begin
          flag_d[i_q[IW-1:2]] = 1'b1;
        end
        if (i_q == nw_of(mode_q) - IW'(1)) begin
          state_d = DONE;
        end else begin
          i_d = i_q + IW'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      sub_q   <= 3'd0;
      rcon_q  <= 8'h01;
      mode_q  <= 2'b00;
      flag_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      sub_q   <= sub_d;
      rcon_q  <= rcon_d;
      mode_q  <= mode_d;
      flag_q  <= flag_d;
      err_q   <= err_d;
    end
  end

  // Key latch and word storage need no reset; nothing reads them as valid
  // until a new expansion has rewritten them.
  always_ff @(posedge clk) begin
    key_q <= key_d;
    w_q   <= w_d;
  end

  assign bus.busy = (state_q == LOAD) || (state_q == GEN);
  assign bus.done = (state_q == DONE);
  assign bus.err  = err_q;

  logic [15:0]     flag_ext;
  logic            rd_ok;
  logic [IW-1:0]   rd_base;
  logic [127:0]    rd_data;

  // Round-key read: the index is range-checked against the latched mode
  // before it is used, so the word address never leaves the array.
  always_comb begin
    flag_ext           = '0;
    flag_ext[NF-1:0]   = flag_q;
    rd_ok              = (bus.rk_idx <= nr_of(mode_q)) && flag_ext[bus.rk_idx];
    rd_base            = rd_ok ? IW'({bus.rk_idx, 2'b00}) : '0;
    if (rd_ok) begin
      rd_data = {w_q[rd_base], w_q[rd_base + IW'(1)],
                 w_q[rd_base + IW'(2)], w_q[rd_base + IW'(3)]};
    end else begin
      rd_data = '0;
    end
  end

  generate
    if (RD_REG) begin : g_rd_reg
      logic         rd_vld_q, rd_vld_d;
      logic [127:0] rd_out_q, rd_out_d;

      // The accepting edge also drops the registered output so the cycle
      // after a start never shows a key from the previous expansion.
      always_comb begin
        rd_vld_d = rd_ok && !accept;
        rd_out_d = rd_vld_d ? rd_data : '0;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rd_vld_q <= 1'b0;
          rd_out_q <= '0;
        end else begin
          rd_vld_q <= rd_vld_d;
          rd_out_q <= rd_out_d;
        end
      end

      assign bus.rk_vld = rd_vld_q;
      assign bus.rk_out = rd_out_q;
    end else begin : g_rd_comb
      assign bus.rk_vld = rd_ok;
      assign bus.rk_out = rd_data;
    end
  endgenerate

endmodule

// File: tb/tb_key_expand_multi.sv
// ---------------------------------------------------------------------------
// tb_key_expand_multi
// Directed bench for key_expand_multi (MAX_NK=8, RD_REG=1) using the FIPS-197
// key expansion examples. A table of {mode, key, read index, expected round
// key, expected latency} records drives full expansions; short hand-written
// sequences cover polling during GEN, rejected starts, starts while busy or
// in DONE, and reset in the middle of an expansion.
// ---------------------------------------------------------------------------
module tb_key_expand_multi;

  logic clk = 1'b0;
  logic rst = 1'b1;

  key_expand_multi_if bus ();

  key_expand_multi #(
    .MAX_NK(8),
    .RD_REG(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] R128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  typedef struct {
    logic [1:0]   kl;
    logic [255:0] key;
    logic [3:0]   idx;
    logic         vld;
    logic [127:0] rk;
    int           lat;
  } vec_t;

  vec_t vecs[10];

  int n_cmp  = 0;
  int n_fail = 0;

  // Compare one value against its expected value and log a FAIL line on mismatch.
  task automatic checkOutput(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Start one expansion and wait (bounded) for done; optionally pulse start
  // again at cycle 'poke' to show it is ignored. lat = -1 on timeout.
  task automatic applyStimulus(input logic [1:0] kl, input logic [255:0] k, input int poke,
                               output int lat, output int errs);
    lat  = -1;
    errs = 0;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.key_len = kl;
    bus.key     = k;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      if (bus.err) errs++;
      if (bus.done) begin
        lat = c;
        break;
      end
      if (c == poke) begin
        bus.start   = 1'b1;
        bus.key_len = 2'b10;
        bus.key     = {8{32'hdeadbeef}};
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
  endtask

  // Read one round key through the registered port.
  task automatic readRound(input logic [3:0] idx, output logic vld, output logic [127:0] rk);
    @(negedge clk);
    bus.rk_idx = idx;
    @(posedge clk);
    @(negedge clk);
    vld = bus.rk_vld;
    rk  = bus.rk_out;
  endtask

  // AES-128 run with rk_idx held from before start; records how rk_vld behaves.
  task automatic pollRun(input logic [3:0] idx, output int lat, output logic vld_c1,
                         output int rise, output logic rise_busy, output logic [127:0] rise_rk,
                         output int vld_cnt);
    lat = -1; vld_c1 = 1'bx; rise = -1; rise_busy = 1'b0; rise_rk = '0; vld_cnt = 0;
    @(negedge clk);
    bus.rk_idx  = idx;
    bus.start   = 1'b1;
    bus.key_len = 2'b00;
    bus.key     = K128;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      if (c == 1) vld_c1 = bus.rk_vld;
      if (bus.rk_vld) vld_cnt++;
      if (bus.rk_vld && rise < 0) begin
        rise      = c;
        rise_busy = bus.busy;
        rise_rk   = bus.rk_out;
      end
      if (bus.done) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int           lat, errs, cnt, cnt2, rise, vcnt;
    logic         vld, vld_c1, rbusy;
    logic [127:0] rk, rrk;

    vecs[0] = '{2'b00, K128, 4'd10, 1'b1, R128_10, 42};
    vecs[1] = '{2'b00, K128, 4'd1,  1'b1, 128'ha0fafe1788542cb123a339392a6c7605, 42};
    vecs[2] = '{2'b00, K128, 4'd11, 1'b0, 128'h0, 42};
    vecs[3] = '{2'b01, K192, 4'd12, 1'b1, 128'he98ba06f448c773c8ecc720401002202, 48};
    vecs[4] = '{2'b01, K192, 4'd1,  1'b1, 128'h62f8ead2522c6b7bfe0c91f72402f5a5, 48};
    vecs[5] = '{2'b01, K192, 4'd13, 1'b0, 128'h0, 48};
    vecs[6] = '{2'b10, K256, 4'd14, 1'b1, 128'hfe4890d1e6188d0b046df344706c631e, 54};
    vecs[7] = '{2'b10, K256, 4'd2,  1'b1, 128'h9ba354118e6925afa51a8b5f2067fcde, 54};
    vecs[8] = '{2'b10, K256, 4'd15, 1'b0, 128'h0, 54};
    vecs[9] = '{2'b00, K128, 4'd0,  1'b1, K128[255:128], 42};

    bus.start   = 1'b0;
    bus.key_len = 2'b00;
    bus.key     = '0;
    bus.rk_idx  = 4'd0;
    rst         = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset_outputs", 160'({bus.busy, bus.done, bus.err, bus.rk_vld, bus.rk_out}), 160'(0));
    rst = 1'b0;

    // Table-driven expansions and read-backs.
    for (int v = 0; v < 10; v++) begin
      applyStimulus(vecs[v].kl, vecs[v].key, 0, lat, errs);
      checkOutput($sformatf("latency_v%0d", v), 160'(lat), 160'(vecs[v].lat));
      readRound(vecs[v].idx, vld, rk);
      checkOutput($sformatf("round_key_v%0d", v), 160'({vld, rk}), 160'({vecs[v].vld, vecs[v].rk}));
    end

    // Poll round 0 from the start: not valid in the LOAD cycle, rises in GEN
    // with the key itself.
    pollRun(4'd0, lat, vld_c1, rise, rbusy, rrk, vcnt);
    checkOutput("poll0_latency", 160'(lat), 160'(42));
    checkOutput("poll0_vld_cycle1", 160'(vld_c1), 160'(0));
    checkOutput("poll0_rise_in_gen", 160'({rbusy, rise > 1 && rise < 42}), 160'(2'b11));
    checkOutput("poll0_rise_data", 160'(rrk), 160'(K128[255:128]));

    // Index beyond Nr never reports valid.
    pollRun(4'd11, lat, vld_c1, rise, rbusy, rrk, vcnt);
    checkOutput("poll11_vld_count", 160'(vcnt), 160'(0));

    // Reserved key_len: single err pulse, no busy, stored keys untouched.
    @(negedge clk);
    bus.start   = 1'b1;
    bus.key_len = 2'b11;
    bus.key     = K256;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    cnt = 0; cnt2 = 0;
    for (int c = 0; c < 5; c++) begin
      if (bus.err) cnt++;
      if (bus.busy) cnt2++;
      @(negedge clk);
    end
    checkOutput("bad_len_err_pulses", 160'(cnt), 160'(1));
    checkOutput("bad_len_busy", 160'(cnt2), 160'(0));
    readRound(4'd10, vld, rk);
    checkOutput("bad_len_keys_kept", 160'({vld, rk}), 160'({1'b1, R128_10}));

    // Start during GEN is ignored; then a start held only in the DONE cycle.
    applyStimulus(2'b00, K128, 10, lat, errs);
    checkOutput("gen_start_latency", 160'(lat), 160'(42));
    checkOutput("gen_start_err", 160'(errs), 160'(0));
    bus.start   = 1'b1;
    bus.key_len = 2'b10;
    bus.key     = K256;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    cnt = 0;
    for (int c = 0; c < 4; c++) begin
      if (bus.busy || bus.err) cnt++;
      @(negedge clk);
    end
    checkOutput("done_start_ignored", 160'(cnt), 160'(0));
    readRound(4'd10, vld, rk);
    checkOutput("gen_start_round10", 160'({vld, rk}), 160'({1'b1, R128_10}));

    // Reset at GEN cycle 20 aborts the expansion immediately.
    @(negedge clk);
    bus.rk_idx  = 4'd0;
    bus.start   = 1'b1;
    bus.key_len = 2'b00;
    bus.key     = K128;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 1; c < 20; c++) @(negedge clk);
    checkOutput("pre_reset_busy_vld", 160'({bus.busy, bus.rk_vld}), 160'(2'b11));
    rst = 1'b1;
    #1;
    checkOutput("mid_reset_outputs", 160'({bus.busy, bus.done, bus.rk_vld, bus.rk_out}), 160'(0));
    cnt = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.done) cnt++;
    end
    rst = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (bus.done || bus.busy) cnt++;
    end
    checkOutput("aborted_no_done", 160'(cnt), 160'(0));
    applyStimulus(2'b00, K128, 0, lat, errs);
    checkOutput("post_reset_latency", 160'(lat), 160'(42));
    readRound(4'd10, vld, rk);
    checkOutput("post_reset_round10", 160'({vld, rk}), 160'({1'b1, R128_10}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/key_expand_multi.md
KEY_EXPAND_MULTI -- requirements
Module: key_expand_multi

Interface
REQ-001 Parameter MAX_NK, default 8, meaning the largest key length in 32-bit words that is supported; legal values are 4, 6 and 8.
REQ-002 Parameter RD_REG, default 1, meaning the read port is registered when 1 and combinational when 0.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous reset, active-high.
REQ-005 start  input  1  request to expand a key; sampled only in IDLE.
REQ-006 key_len  input  2  mode: 00 = AES-128 (Nk=4, Nr=10), 01 = AES-192 (Nk=6, Nr=12), 10 = AES-256 (Nk=8, Nr=14), 11 = reserved.
REQ-007 key  input  256  cipher key, MSB-aligned; word 0 = key[255:224]; unused low words ignored.
REQ-008 busy  output  1  high while in LOAD or GEN.
REQ-009 done  output  1  one-cycle pulse when the expansion is complete.
REQ-010 err  output  1  one-cycle pulse when a start is rejected.
REQ-011 rk_idx  input  4  round-key index to read (0..Nr).
REQ-012 rk_out  output  128  round key rk_idx = {w[4*idx], w[4*idx+1], w[4*idx+2], w[4*idx+3]}.
REQ-013 rk_vld  output  1  rk_out holds a fully generated round key.

Function
REQ-014 The FSM SHALL have four states: IDLE, LOAD, GEN and DONE.
REQ-015 IDLE: a start with a supported key_len SHALL latch key and key_len and go to LOAD; busy rises on the next cycle.
REQ-016 A start with key_len=11, or with Nk>MAX_NK, SHALL pulse err for one cycle, keep the FSM in IDLE and leave stored words untouched.
REQ-017 LOAD SHALL write w[0..Nk-1] from the latched key in one cycle, set i=Nk and rcon=0x01, then go to GEN.
REQ-018 GEN SHALL write exactly one word w[i] per cycle for i = Nk .. 4*(Nr+1)-1, giving 40, 46 or 52 GEN cycles for AES-128, AES-192 and AES-256.
REQ-019 The word rule is w[i] = w[i-Nk] ^ t, where t is computed from w[i-1] as follows:
- i mod Nk = 0: t = SubWord(RotWord(w[i-1])) ^ {rcon, 24'h0}; rcon is then doubled in GF(2^8) (0x80 -> 0x1b).
- Nk = 8 and i mod 8 = 4: t = SubWord(w[i-1]).
- otherwise: t = w[i-1].
REQ-020 i mod Nk SHALL be tracked by a wrapping sub-counter, with no divider.
REQ-021 After the last word is written the FSM SHALL enter DONE, assert done for exactly one cycle, then return to IDLE.
REQ-022 Total latency SHALL be 2 + (Nw - Nk) cycles from the start-sampling edge to done high (42, 48 or 54 cycles).
REQ-023 start asserted in LOAD, GEN or DONE SHALL be ignored, with no err.
REQ-024 start asserted in the DONE cycle SHALL also be ignored; it is re-sampled in IDLE.
REQ-025 The read port SHALL be usable during GEN: rk_vld=1 only if w[4*idx+3] has been written by the current expansion.
REQ-026 rk_vld SHALL be 0 when rk_idx > Nr of the latched mode.
REQ-027 When rk_vld=0, rk_out SHALL be all zeros.
REQ-028 With RD_REG=1, rk_out and rk_vld SHALL reflect the rk_idx sampled on the previous edge (1-cycle latency); with RD_REG=0 they are combinational.
REQ-029 Round keys from a completed expansion SHALL remain readable in IDLE until the next accepted start, which clears all per-round valid flags in LOAD.
REQ-030 Storage SHALL be 4*(MAX_NK+7) words; logic for unsupported modes SHALL be removable by MAX_NK.

Reset
REQ-031 rst high SHALL asynchronously force IDLE, clear i, set rcon=0x01 and clear all valid flags.
REQ-032 While rst is high, busy, done, err, rk_vld and rk_out SHALL all be 0; the word array need not be cleared.
REQ-033 Reset during GEN SHALL abort the expansion with no done pulse.
REQ-034 After reset is released, the first start SHALL behave as from power-up.

Verification
REQ-035 AES-128, key 2b7e1516_28aed2a6_abf71588_09cf4f3c: done 42 cycles after start -> rk_idx=10 reads d014f9a8_c9ee2589_e13f0cc8_b6630ca6, rk_vld=1.
REQ-036 AES-192, key 8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b: done at 48 cycles -> rk_idx=12 reads e98ba06f_448c773c_8ecc7204_01002202.
REQ-037 AES-256, key 603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4: done at 54 cycles -> rk_idx=14 reads fe4890d1_e6188d0b_046df344_706c631e; rk_idx=15 -> rk_vld=0, rk_out=0.
REQ-038 AES-128 run: rk_idx=0 polled from start -> rk_vld rises in GEN and returns the key itself; rk_idx=11 -> rk_vld=0 throughout.
REQ-039 Start with key_len=11 -> single err pulse, busy stays 0; a start during GEN -> no effect, done still at 42 cycles.
REQ-040 rst pulsed at GEN cycle 20 -> busy, done and rk_vld all 0 immediately, no done pulse; a following AES-128 run matches REQ-035.
